// File: rtl/core_select_encoder.sv
// rtl/core_select_encoder.sv - one-hot core select receiver, address encoder and read/restore sequencer
//
// Purpose:
//    Samples the active-low AX units, AX tens and AY select groups on a memory
//    cycle request. If every group is one-hot, it encodes them to a 9-bit address
//    and runs a destructive-readout core cycle: a read phase, then a restore
//    (write) phase, then a one-clock DONE pulse. An invalid group raises a sticky
//    select fault and skips straight to completion.
//
// Parameters:
//    READ_CYCLES   clocks o_read_en is held high (1..15)
//    WRITE_CYCLES  clocks o_write_en is held high (1..15)
//
// Ports:
//    i_clk        system clock, rising edge
//    i_reset      asynchronous active-high reset
//    i_cycle      memory cycle request, accepted only while idle
//    i_axn[7:0]   AX0N..AX7N, active-low, bit i = AXiN
//    i_axxn[7:0]  AX00N..AX70N, active-low, bit i = AX(i)0N
//    i_ayn[7:0]   AY0N..AY7N, active-low, bit i = AYiN
//    i_err_clr    clears o_sel_err (and o_err_count when present)
//    o_addr[8:0]  encoded address {AXX index, AY index, AX index}
//    o_read_en    read-phase drive
//    o_write_en   restore-phase drive
//    o_busy       cycle in progress (SAMPLE/READ/WRITE)
//    o_done       one-clock completion pulse
//    o_sel_err    sticky select-fault flag
//    o_err_count  saturating select-fault counter (only with SEL_ERR_COUNT_EN)
//
// Optional feature macro: SEL_ERR_COUNT_EN adds the o_err_count port and counter.

module core_select_encoder #(
   parameter int READ_CYCLES  = 4,
   parameter int WRITE_CYCLES = 4
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_cycle,
   input  logic [7:0] i_axn,
   input  logic [7:0] i_axxn,
   input  logic [7:0] i_ayn,
   input  logic       i_err_clr,
   output logic [8:0] o_addr,
   output logic       o_read_en,
   output logic       o_write_en,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_sel_err
`ifdef SEL_ERR_COUNT_EN
   ,
   output logic [7:0] o_err_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SAMPLE,
      S_READ,
      S_WRITE,
      S_FIN
   } state_t;

   localparam logic [3:0] LP_RD_LAST = 4'(READ_CYCLES - 1);
   localparam logic [3:0] LP_WR_LAST = 4'(WRITE_CYCLES - 1);

   state_t     r_state;
   logic       r_req;
   logic [3:0] r_phase_cnt;

   logic [3:0] w_ax_enc;
   logic [3:0] w_ay_enc;
   logic [3:0] w_axx_enc;
   logic       w_all_valid;

   // Returns {valid, index}: valid when exactly one bit is low, index is the
   // position of that low bit.
   function automatic logic [3:0] f_encode(input logic [7:0] grp_n);
      logic [2:0] idx;
      logic [3:0] n_low;
      idx   = 3'd0;
      n_low = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (!grp_n[i]) begin
            idx   = i[2:0];
            n_low = n_low + 4'd1;
         end
      end
      return {(n_low == 4'd1), idx};
   endfunction

   assign w_ax_enc    = f_encode(i_axn);
   assign w_ay_enc    = f_encode(i_ayn);
   assign w_axx_enc   = f_encode(i_axxn);
   assign w_all_valid = w_ax_enc[3] & w_ay_enc[3] & w_axx_enc[3];

`ifdef SEL_ERR_COUNT_EN
   logic [7:0] r_err_count;
   assign o_err_count = r_err_count;
`endif

   // r_req holds an accepted request for one clock so that SAMPLE occupies the
   // clock after the request edge; it is only armed from a quiet IDLE, so a
   // request seen in FIN or while already pending is dropped rather than queued.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_req       <= 1'b0;
         r_phase_cnt <= 4'd0;
         o_addr      <= 9'd0;
         o_read_en   <= 1'b0;
         o_write_en  <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_sel_err   <= 1'b0;
`ifdef SEL_ERR_COUNT_EN
         r_err_count <= 8'd0;
`endif
      end else begin
         o_done <= 1'b0;

         // Clear first; a fault raised in SAMPLE below overrides it.
         if (i_err_clr) begin
            o_sel_err <= 1'b0;
`ifdef SEL_ERR_COUNT_EN
            r_err_count <= 8'd0;
`endif
         end

         case (r_state)
            S_IDLE: begin
               if (r_req) begin
                  r_req   <= 1'b0;
                  r_state <= S_SAMPLE;
                  o_busy  <= 1'b1;
               end else if (i_cycle) begin
                  r_req <= 1'b1;
               end
            end

            S_SAMPLE: begin
               if (w_all_valid) begin
                  o_addr      <= {w_axx_enc[2:0], w_ay_enc[2:0], w_ax_enc[2:0]};
                  o_read_en   <= 1'b1;
                  r_phase_cnt <= 4'd0;
                  r_state     <= S_READ;
               end else begin
                  o_sel_err <= 1'b1;
`ifdef SEL_ERR_COUNT_EN
                  if (i_err_clr) begin
                     r_err_count <= 8'd1;
                  end else if (r_err_count != 8'hFF) begin
                     r_err_count <= r_err_count + 8'd1;
                  end
`endif
                  o_busy  <= 1'b0;
                  o_done  <= 1'b1;
                  r_state <= S_FIN;
               end
            end

            S_READ: begin
               if (r_phase_cnt == LP_RD_LAST) begin
                  // Hand over directly so the drives never overlap or gap.
                  o_read_en   <= 1'b0;
                  o_write_en  <= 1'b1;
                  r_phase_cnt <= 4'd0;
                  r_state     <= S_WRITE;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 4'd1;
               end
            end

            S_WRITE: begin
               if (r_phase_cnt == LP_WR_LAST) begin
                  o_write_en  <= 1'b0;
                  o_busy      <= 1'b0;
                  o_done      <= 1'b1;
                  r_phase_cnt <= 4'd0;
                  r_state     <= S_FIN;
               end else begin
                  r_phase_cnt <= r_phase_cnt + 4'd1;
               end
            end

            S_FIN: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state    <= S_IDLE;
               r_req      <= 1'b0;
               o_read_en  <= 1'b0;
               o_write_en <= 1'b0;
               o_busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_core_select_encoder.sv
// tb/tb_core_select_encoder.sv - self-checking bench for core_select_encoder

module tb_core_select_encoder;

   localparam int R = 4;
   localparam int W = 4;

   logic       i_clk     = 1'b0;
   logic       i_reset   = 1'b1;
   logic       i_cycle   = 1'b0;
   logic       i_err_clr = 1'b0;
   logic [7:0] i_axn     = 8'hFF;
   logic [7:0] i_axxn    = 8'hFF;
   logic [7:0] i_ayn     = 8'hFF;
   logic [8:0] o_addr;
   logic       o_read_en;
   logic       o_write_en;
   logic       o_busy;
   logic       o_done;
   logic       o_sel_err;
`ifdef SEL_ERR_COUNT_EN
   logic [7:0] o_err_count;
`endif

   core_select_encoder #(
      .READ_CYCLES (R),
      .WRITE_CYCLES(W)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_cycle   (i_cycle),
      .i_axn     (i_axn),
      .i_axxn    (i_axxn),
      .i_ayn     (i_ayn),
      .i_err_clr (i_err_clr),
      .o_addr    (o_addr),
      .o_read_en (o_read_en),
      .o_write_en(o_write_en),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_sel_err (o_sel_err)
`ifdef SEL_ERR_COUNT_EN
      ,
      .o_err_count(o_err_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a cycle is described by its start edge and whether
   // its groups were valid; every output follows from the clock offset.
   int         m_edge   = 0;
   int         m_start  = 0;
   int         m_end    = 0;
   bit         m_active = 0;
   bit         m_valid  = 0;
   logic [8:0] m_addr   = 9'd0;
   bit         m_err    = 0;
   int         m_cnt    = 0;

   function automatic int grp_idx(input logic [7:0] g);
      logic [7:0] lo;
      lo = ~g;
      if ($countones(lo) != 1) return -1;
      for (int i = 0; i < 8; i++) if (lo[i]) return i;
      return -1;
   endfunction

   always @(posedge i_clk or posedge i_reset) begin
      int  dprev;
      int  d;
      int  ix;
      int  iy;
      int  ixx;
      bit  set_now;
      if (i_reset) begin
         m_active = 0;
         m_valid  = 0;
         m_addr   = 9'd0;
         m_err    = 0;
         m_cnt    = 0;
      end else begin
         m_edge++;
         set_now = 0;
         dprev   = m_edge - 1 - m_start;
         if (!m_active || dprev >= m_end) begin
            m_active = 0;
            if (i_cycle) begin
               m_active = 1;
               m_valid  = 0;
               m_start  = m_edge;
               m_end    = 1000;
            end
         end else begin
            d = m_edge - m_start;
            if (d == 2) begin
               ix  = grp_idx(i_axn);
               iy  = grp_idx(i_ayn);
               ixx = grp_idx(i_axxn);
               if (ix >= 0 && iy >= 0 && ixx >= 0) begin
                  m_valid = 1;
                  m_addr  = 9'(ixx * 64 + iy * 8 + ix);
                  m_end   = R + W + 3;
               end else begin
                  set_now = 1;
                  m_end   = 3;
               end
            end
         end
         if (set_now) begin
            m_err = 1;
            m_cnt = i_err_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
         end else if (i_err_clr) begin
            m_err = 0;
            m_cnt = 0;
         end
      end
   end

   always @(negedge i_clk) begin
      int d;
      bit e_busy;
      bit e_rd;
      bit e_wr;
      bit e_done;
      if (!i_reset) begin
         d      = m_edge - m_start;
         e_busy = m_active && d >= 1 && d < m_end - 1;
         e_rd   = m_active && m_valid && d >= 2 && d < 2 + R;
         e_wr   = m_active && m_valid && d >= 2 + R && d < 2 + R + W;
         e_done = m_active && d == m_end - 1;
         chk("m_busy", o_busy, e_busy);
         chk("m_read_en", o_read_en, e_rd);
         chk("m_write_en", o_write_en, e_wr);
         chk("m_done", o_done, e_done);
         chk("m_addr", o_addr, m_addr);
         chk("m_sel_err", o_sel_err, m_err);
`ifdef SEL_ERR_COUNT_EN
         chk("m_err_count", o_err_count, m_cnt);
`endif
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic pulse_cycle();
      i_cycle = 1'b1;
      tick();
      i_cycle = 1'b0;
   endtask

   task automatic observe(input int n, output logic [15:0] rd, output logic [15:0] wr,
                          output logic [15:0] dn, output logic [15:0] bz);
      rd = '0;
      wr = '0;
      dn = '0;
      bz = '0;
      for (int k = 1; k <= n; k++) begin
         tick();
         rd[k] = o_read_en;
         wr[k] = o_write_en;
         dn[k] = o_done;
         bz[k] = o_busy;
      end
   endtask

   function automatic logic [7:0] rand_group();
      logic [7:0] one;
      if ($urandom_range(0, 3) != 0) begin
         one = 8'h01 << $urandom_range(0, 7);
         return ~one;
      end
      return 8'($urandom);
   endfunction

   logic [15:0] v_rd;
   logic [15:0] v_wr;
   logic [15:0] v_dn;
   logic [15:0] v_bz;

   initial begin
      // Reset state
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_addr", o_addr, 9'd0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_read_en", o_read_en, 1'b0);
      chk("rst_sel_err", o_sel_err, 1'b0);
      i_reset = 1'b0;
      tick();
      tick();

      // Valid cycle: address 0x1A5, read 4 clocks from offset 2, write next 4
      i_axn  = 8'hDF;
      i_ayn  = 8'hEF;
      i_axxn = 8'hBF;
      pulse_cycle();
      observe(12, v_rd, v_wr, v_dn, v_bz);
      chk("valid_rd_window", v_rd, 16'h003C);
      chk("valid_wr_window", v_wr, 16'h03C0);
      chk("valid_done", v_dn, 16'h0400);
      chk("valid_busy", v_bz, 16'h03FE);
      chk("valid_addr", o_addr, 9'h1A5);
      chk("model_addr_pin", m_addr, 9'h1A5);
      chk("valid_sel_err", o_sel_err, 1'b0);

      // Double select on AX
      i_axn = 8'hFC;
      pulse_cycle();
      observe(6, v_rd, v_wr, v_dn, v_bz);
      chk("dbl_done", v_dn, 16'h0004);
      chk("dbl_rd", v_rd, 16'h0000);
      chk("dbl_wr", v_wr, 16'h0000);
      chk("dbl_busy", v_bz, 16'h0002);
      chk("dbl_addr", o_addr, 9'h1A5);
      chk("dbl_sel_err", o_sel_err, 1'b1);
      chk("model_err_pin", m_err, 1'b1);
      i_axn = 8'hDF;

      // Clear, then no select on AY
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("clr_sel_err", o_sel_err, 1'b0);
      i_ayn = 8'hFF;
      pulse_cycle();
      observe(6, v_rd, v_wr, v_dn, v_bz);
      chk("none_done", v_dn, 16'h0004);
      chk("none_rd", v_rd, 16'h0000);
      chk("none_addr", o_addr, 9'h1A5);
      chk("none_sel_err", o_sel_err, 1'b1);

      // Clear in the same clock as an invalid SAMPLE: set wins
      pulse_cycle();
      tick();
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("setwins_sel_err", o_sel_err, 1'b1);
      tick();
      tick();
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("clr_alone_sel_err", o_sel_err, 1'b0);
      i_ayn = 8'hEF;

      // Requests during READ and FIN are dropped; AX change mid-WRITE ignored
      pulse_cycle();
      v_bz = '0;
      for (int k = 1; k <= 14; k++) begin
         i_cycle = (k == 3 || k == 11);
         if (k == 8) i_axn = 8'h7F;
         tick();
         v_bz[k] = o_busy;
      end
      i_cycle = 1'b0;
      chk("busy_single_cycle", v_bz, 16'h03FE);
      chk("busy_addr_held", o_addr, 9'h1A5);
      i_axn = 8'hDF;
      tick();

      // Reset during the second READ clock
      pulse_cycle();
      tick();
      tick();
      tick();
      #2;
      i_reset = 1'b1;
      #1;
      chk("midrst_read_en", o_read_en, 1'b0);
      chk("midrst_busy", o_busy, 1'b0);
      chk("midrst_addr", o_addr, 9'd0);
      chk("midrst_done", o_done, 1'b0);
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      tick();
      pulse_cycle();
      observe(12, v_rd, v_wr, v_dn, v_bz);
      chk("postrst_rd", v_rd, 16'h003C);
      chk("postrst_done", v_dn, 16'h0400);
      chk("postrst_addr", o_addr, 9'h1A5);

      // Randomized traffic against the model
      for (int n = 0; n < 1500; n++) begin
         i_cycle   = ($urandom_range(0, 3) == 0);
         i_err_clr = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 2) == 0) begin
            i_axn  = rand_group();
            i_ayn  = rand_group();
            i_axxn = rand_group();
         end
         tick();
      end
      i_cycle   = 1'b0;
      i_err_clr = 1'b0;
      repeat (20) tick();

`ifdef SEL_ERR_COUNT_EN
      // Saturating fault counter
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      i_axn     = 8'hDF;
      i_axxn    = 8'hBF;
      i_ayn     = 8'hFF;
      for (int n = 0; n < 300; n++) begin
         pulse_cycle();
         tick();
         tick();
         tick();
      end
      chk("count_sat", o_err_count, 8'd255);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("count_clr", o_err_count, 8'd0);
`endif

      repeat (4) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
